// File: rtl/arm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipe_pkg
//
// Shared definitions for the ARM pipeline hazard logic.
//   REG_AW_DEF  : default register-address width
//   REG_AW_MAX  : widest register address a scoreboard entry can hold; narrower
//                 addresses are zero-extended into the dest field
//   FWD_RF      : forwarding-select code meaning "read the register file"
//   sb_entry_t  : one in-flight writer tracked between ID and write-back
// -----------------------------------------------------------------------------
package arm_pipe_pkg;

    localparam int REG_AW_DEF = 4;
    localparam int REG_AW_MAX = 8;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;     // slot holds a real instruction
        logic                  wb_en;     // instruction writes a register
        logic                  mem_read;  // instruction is a load
        logic [REG_AW_MAX-1:0] dest;      // destination register (zero-extended)
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//
// Bundle between the ID stage and the hazard scoreboard.
//   master : the ID stage; drives the decoded instruction fields and flush,
//            receives stall, forwarding selects and the status outputs
//   slave  : the scoreboard; the reverse directions
//
// Signals:
//   id_valid               ID holds a real instruction
//   id_rn / id_rm          source register addresses
//   id_rn_used / id_rm_used  source is actually read
//   id_wb_en / id_mem_read ID instruction writes back / is a load
//   id_dest                ID destination register
//   flush                  taken branch, ID instruction is discarded
//   stall                  freeze IF/ID, bubble into EX
//   fwd_sel_rn / fwd_sel_rm  0 = register file, k = result of entry k-1
//   inflight               number of valid writers in the scoreboard
//   stall_cnt              saturating stall-cycle count
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_AW = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic              id_rn_used;
    logic              id_rm_used;
    logic              id_wb_en;
    logic              id_mem_read;
    logic [REG_AW-1:0] id_dest;
    logic              flush;

    logic              stall;
    logic [SEL_W-1:0]  fwd_sel_rn;
    logic [SEL_W-1:0]  fwd_sel_rm;
    logic [SEL_W-1:0]  inflight;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
               id_wb_en, id_mem_read, id_dest, flush,
        input  stall, fwd_sel_rn, fwd_sel_rm, inflight, stall_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used,
               id_wb_en, id_mem_read, id_dest, flush,
        output stall, fwd_sel_rn, fwd_sel_rm, inflight, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
//
// Combinational comparator for one source operand against every scoreboard
// entry, followed by a youngest-first priority encoder.
//   src, src_used : source register and whether the instruction reads it
//   entries       : scoreboard contents, index 0 is the youngest (EX)
//   hit           : some valid writer targets src
//   idx           : index of the youngest such writer
//   is_load       : that writer is a load
// -----------------------------------------------------------------------------
module hazard_match
    import arm_pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 2,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [REG_AW-1:0]     src,
    input  logic                  src_used,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx,
    output logic                  is_load
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path
        // leaves one unassigned and no latch is inferred.
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        // NOTE: blocking assignments let a later iteration overwrite an
        // earlier one; scanning from the oldest entry down to entry 0 makes
        // the youngest matching writer the one that survives.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_used && entries[k].valid && entries[k].wb_en &&
                (entries[k].dest == REG_AW_MAX'(src))) begin
                hit     = 1'b1;
                idx     = IDX_W'(k);
                is_load = entries[k].mem_read;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard detection and forwarding control at the ID/EX boundary. Every writer
// leaving ID is tracked in a DEPTH-entry shift register until its result is
// visible in the register file. Each cycle the ID sources are checked against
// it to produce a stall and per-source forwarding selects.
//
// Parameters:
//   REG_AW   register-address width (at most arm_pipe_pkg::REG_AW_MAX)
//   DEPTH    tracked stages after ID (entry 0 = EX, entry 1 = MEM, ...)
//   FWD_EN   1 = forwarding mode, 0 = stall-only mode
//   LOAD_LAT lowest entry index from which a load result can be forwarded
//   CNT_W    stall-counter width
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  hazard_scoreboard_if slave: ID fields and flush in; stall,
//        fwd_sel_rn/rm, inflight and stall_cnt out (all combinational from
//        the current scoreboard except stall_cnt, which is registered)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int DEPTH    = 2,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t [DEPTH-1:0] sb_d;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;

    // -------------------------------------------------------------------------
    // Per-source match against the scoreboard
    // -------------------------------------------------------------------------
    logic             rn_hit;
    logic             rm_hit;
    logic [IDX_W-1:0] rn_idx;
    logic [IDX_W-1:0] rm_idx;
    logic             rn_is_load;
    logic             rm_is_load;

    hazard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_match_rn (
        .src      (bus.id_rn),
        .src_used (bus.id_rn_used),
        .entries  (sb_q),
        .hit      (rn_hit),
        .idx      (rn_idx),
        .is_load  (rn_is_load)
    );

    hazard_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_match_rm (
        .src      (bus.id_rm),
        .src_used (bus.id_rm_used),
        .entries  (sb_q),
        .hit      (rm_hit),
        .idx      (rm_idx),
        .is_load  (rm_is_load)
    );

    // -------------------------------------------------------------------------
    // Stall qualification
    // -------------------------------------------------------------------------
    logic rn_load_haz;
    logic rm_load_haz;
    logic hazard;
    logic stall;

    always_comb begin
        // A load result only reaches the bypass network once it sits at
        // entry LOAD_LAT or older; a younger load must be waited for.
        rn_load_haz = rn_hit && rn_is_load && (int'(rn_idx) < LOAD_LAT);
        rm_load_haz = rm_hit && rm_is_load && (int'(rm_idx) < LOAD_LAT);

        if (FWD_EN != 0) begin
            hazard = rn_load_haz || rm_load_haz;
        end else begin
            hazard = rn_hit || rm_hit;
        end

        // A flushed or empty ID slot never needs to wait for anything.
        stall = hazard && bus.id_valid && !bus.flush;
    end

    // -------------------------------------------------------------------------
    // Forwarding selects
    // -------------------------------------------------------------------------
    logic [SEL_W-1:0] fwd_sel_rn;
    logic [SEL_W-1:0] fwd_sel_rm;

    always_comb begin
        fwd_sel_rn = SEL_W'(FWD_RF);
        fwd_sel_rm = SEL_W'(FWD_RF);
        // Under stall the ID instruction becomes a bubble, so the selects are
        // parked on the register file. Without stall any hit is forwardable.
        if ((FWD_EN != 0) && !stall) begin
            if (rn_hit) begin
                fwd_sel_rn = SEL_W'(rn_idx) + SEL_W'(1);
            end
            if (rm_hit) begin
                fwd_sel_rm = SEL_W'(rm_idx) + SEL_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard shift: entry 0 takes the ID instruction when it advances,
    // otherwise a bubble. Older entries always shift, flush or not.
    // -------------------------------------------------------------------------
    always_comb begin
        sb_d[0] = '0;
        if (bus.id_valid && !stall && !bus.flush) begin
            sb_d[0].valid    = 1'b1;
            sb_d[0].wb_en    = bus.id_wb_en;
            sb_d[0].mem_read = bus.id_mem_read;
            sb_d[0].dest     = REG_AW_MAX'(bus.id_dest);
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // In-flight writer count
    // -------------------------------------------------------------------------
    logic [SEL_W-1:0] inflight;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sb_q[k].valid && sb_q[k].wb_en) begin
                inflight = inflight + SEL_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall counter
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is a handful of flops, not a RAM, and must be
        // reset: a stale valid bit would raise a phantom stall after reset.
        if (rst) begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.stall      = stall;
    assign bus.fwd_sel_rn = fwd_sel_rn;
    assign bus.fwd_sel_rm = fwd_sel_rm;
    assign bus.inflight   = inflight;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Drives a forwarding-mode and a stall-only-mode scoreboard with identical ID
// streams. A reference model tracks in-flight writers by age (cycles since
// they left ID) and predicts each cycle's outputs; predictions are queued and
// a negedge monitor compares them against both DUTs. Directed sequences add a
// few constant checks on the key scenarios, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int REG_AW   = 4;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared ID-side stimulus
    logic              id_valid;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic              id_rn_used;
    logic              id_rm_used;
    logic              id_wb_en;
    logic              id_mem_read;
    logic [REG_AW-1:0] id_dest;
    logic              flush;

    hazard_scoreboard_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) if_f ();
    hazard_scoreboard_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) if_s ();

    assign if_f.id_valid    = id_valid;
    assign if_f.id_rn       = id_rn;
    assign if_f.id_rm       = id_rm;
    assign if_f.id_rn_used  = id_rn_used;
    assign if_f.id_rm_used  = id_rm_used;
    assign if_f.id_wb_en    = id_wb_en;
    assign if_f.id_mem_read = id_mem_read;
    assign if_f.id_dest     = id_dest;
    assign if_f.flush       = flush;

    assign if_s.id_valid    = id_valid;
    assign if_s.id_rn       = id_rn;
    assign if_s.id_rm       = id_rm;
    assign if_s.id_rn_used  = id_rn_used;
    assign if_s.id_rm_used  = id_rm_used;
    assign if_s.id_wb_en    = id_wb_en;
    assign if_s.id_mem_read = id_mem_read;
    assign if_s.id_dest     = id_dest;
    assign if_s.flush       = flush;

    hazard_scoreboard #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .FWD_EN(1), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut_fwd (
        .clk (clk),
        .rst (rst),
        .bus (if_f.slave)
    );

    hazard_scoreboard #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .FWD_EN(0), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) dut_stl (
        .clk (clk),
        .rst (rst),
        .bus (if_s.slave)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        bit valid; int rn; bit rn_used; int rm; bit rm_used;
        bit wb; bit mr; int dest; bit flush; bit rst;
    } stim_t;

    typedef struct {
        bit stall; int sel_rn; int sel_rm; int inflight; int cnt;
    } exp_t;

    typedef struct { exp_t f; exp_t s; } pair_t;

    // A writer that has left ID; age 1 means it left at the last edge.
    typedef struct { int dest; bit is_load; int age; } writer_t;
    typedef writer_t wq_t[$];

    wq_t   wq_f;
    wq_t   wq_s;
    int    cnt_f;
    int    cnt_s;
    bit    known;
    pair_t expq[$];
    pair_t mon_p;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Age of the youngest writer of src (0 = none); a writer of age a has been
    // in flight a cycles, so forwarding from it uses select code a.
    function automatic int youngest(input wq_t q, input int src, input bit used,
                                    output bit is_load);
        int best;
        best    = 0;
        is_load = 1'b0;
        if (used) begin
            foreach (q[i]) begin
                if (q[i].dest == src && (best == 0 || q[i].age < best)) begin
                    best    = q[i].age;
                    is_load = q[i].is_load;
                end
            end
        end
        return best;
    endfunction

    function automatic exp_t predict(input bit fwd, input wq_t q, input stim_t s,
                                     input int cnt);
        exp_t e;
        int   a_rn, a_rm;
        bit   l_rn, l_rm, haz;
        a_rn = youngest(q, s.rn, s.rn_used, l_rn);
        a_rm = youngest(q, s.rm, s.rm_used, l_rm);
        if (fwd) begin
            // A load can be bypassed only once it has been in flight more than
            // LOAD_LAT cycles.
            haz = (a_rn != 0 && l_rn && a_rn <= LOAD_LAT) ||
                  (a_rm != 0 && l_rm && a_rm <= LOAD_LAT);
        end else begin
            haz = (a_rn != 0) || (a_rm != 0);
        end
        e.stall    = haz && s.valid && !s.flush;
        e.sel_rn   = (fwd && !e.stall) ? a_rn : 0;
        e.sel_rm   = (fwd && !e.stall) ? a_rm : 0;
        e.inflight = q.size();
        e.cnt      = cnt;
        return e;
    endfunction

    function automatic wq_t advance(input wq_t q, input stim_t s, input bit stall);
        wq_t     n;
        writer_t w;
        n = {};
        if (s.rst) return n;
        foreach (q[i]) begin
            if (q[i].age < DEPTH) begin
                w     = q[i];
                w.age = q[i].age + 1;
                n.push_back(w);
            end
        end
        if (s.valid && !stall && !s.flush && s.wb) begin
            w.dest    = s.dest;
            w.is_load = s.mr;
            w.age     = 1;
            n.push_back(w);
        end
        return n;
    endfunction

    function automatic int next_cnt(input int cnt, input stim_t s, input bit stall);
        if (s.rst) return 0;
        if (stall && cnt < CNT_MAX) return cnt + 1;
        return cnt;
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t wr(input int dest, input bit load);
        stim_t s;
        s       = nop();
        s.valid = 1'b1;
        s.wb    = 1'b1;
        s.mr    = load;
        s.dest  = dest;
        return s;
    endfunction

    function automatic stim_t use_rn(input int r);
        stim_t s;
        s         = nop();
        s.valid   = 1'b1;
        s.rn      = r;
        s.rn_used = 1'b1;
        return s;
    endfunction

    function automatic stim_t use_rm(input int r);
        stim_t s;
        s         = nop();
        s.valid   = 1'b1;
        s.rm      = r;
        s.rm_used = 1'b1;
        return s;
    endfunction

    // One ID cycle: drive, predict, queue the prediction, advance the model.
    task automatic step(input stim_t s);
        pair_t p;
        @(posedge clk);
        #1;
        rst         = s.rst;
        id_valid    = s.valid;
        id_rn       = REG_AW'(s.rn);
        id_rm       = REG_AW'(s.rm);
        id_rn_used  = s.rn_used;
        id_rm_used  = s.rm_used;
        id_wb_en    = s.wb;
        id_mem_read = s.mr;
        id_dest     = REG_AW'(s.dest);
        flush       = s.flush;
        p.f = predict(1'b1, wq_f, s, cnt_f);
        p.s = predict(1'b0, wq_s, s, cnt_s);
        if (known) expq.push_back(p);
        wq_f  = advance(wq_f, s, p.f.stall);
        wq_s  = advance(wq_s, s, p.s.stall);
        cnt_f = next_cnt(cnt_f, s, p.f.stall);
        cnt_s = next_cnt(cnt_s, s, p.s.stall);
        if (s.rst) known = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (expq.size() != 0) begin
            mon_p = expq.pop_front();
            check("fwd.stall",      int'(if_f.stall),      int'(mon_p.f.stall));
            check("fwd.fwd_sel_rn", int'(if_f.fwd_sel_rn), mon_p.f.sel_rn);
            check("fwd.fwd_sel_rm", int'(if_f.fwd_sel_rm), mon_p.f.sel_rm);
            check("fwd.inflight",   int'(if_f.inflight),   mon_p.f.inflight);
            check("fwd.stall_cnt",  int'(if_f.stall_cnt),  mon_p.f.cnt);
            check("stl.stall",      int'(if_s.stall),      int'(mon_p.s.stall));
            check("stl.fwd_sel_rn", int'(if_s.fwd_sel_rn), mon_p.s.sel_rn);
            check("stl.fwd_sel_rm", int'(if_s.fwd_sel_rm), mon_p.s.sel_rm);
            check("stl.inflight",   int'(if_s.inflight),   mon_p.s.inflight);
            check("stl.stall_cnt",  int'(if_s.stall_cnt),  mon_p.s.cnt);
        end
    end

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        stim_t s;
        known = 1'b0;
        cnt_f = 0;
        cnt_s = 0;
        rst = 1'b1; id_valid = 1'b0; id_rn = '0; id_rm = '0; id_rn_used = 1'b0;
        id_rm_used = 1'b0; id_wb_en = 1'b0; id_mem_read = 1'b0; id_dest = '0;
        flush = 1'b0;

        // Reset held two cycles with a valid ID instruction
        s = nop(); s.rst = 1'b1; s.valid = 1'b1;
        step(s);
        step(s);
        #1;
        check("reset.stall",     int'(if_f.stall),      0);
        check("reset.fwd_sel",   int'(if_f.fwd_sel_rn), 0);
        check("reset.inflight",  int'(if_f.inflight),   0);
        check("reset.stall_cnt", int'(if_s.stall_cnt),  0);

        // Stall-only: ADD r3 then a reader of r3 stalls exactly DEPTH cycles
        step(wr(3, 1'b0));
        step(use_rn(3)); #1;
        check("stl.dep.stall1", int'(if_s.stall), 1);
        check("fwd.dep.sel",    int'(if_f.fwd_sel_rn), 1);
        step(use_rn(3)); #1;
        check("stl.dep.stall2", int'(if_s.stall), 1);
        step(use_rn(3)); #1;
        check("stl.dep.released", int'(if_s.stall), 0);
        check("stl.dep.cnt",      int'(if_s.stall_cnt), 2);
        step(wr(3, 1'b0));
        s = use_rn(3); s.rn_used = 1'b0;
        step(s); #1;
        check("stl.unused_src", int'(if_s.stall), 0);

        // Forwarding: ALU result from EX, then from MEM after one bubble
        step(nop()); step(nop());
        step(wr(3, 1'b0));
        step(use_rm(3)); #1;
        check("fwd.ex.stall", int'(if_f.stall), 0);
        check("fwd.ex.sel",   int'(if_f.fwd_sel_rm), 1);
        step(nop()); step(nop());
        step(wr(3, 1'b0));
        step(nop());
        step(use_rm(3)); #1;
        check("fwd.mem.sel", int'(if_f.fwd_sel_rm), 2);

        // Load-use: one stall, then forward from MEM
        step(nop()); step(nop());
        step(wr(5, 1'b1));
        step(use_rn(5)); #1;
        check("fwd.load.stall", int'(if_f.stall), 1);
        step(use_rn(5)); #1;
        check("fwd.load.release", int'(if_f.stall), 0);
        check("fwd.load.sel",     int'(if_f.fwd_sel_rn), 2);

        // Youngest writer wins; a non-writing entry never matches
        step(nop()); step(nop());
        step(wr(4, 1'b0));
        step(wr(4, 1'b0));
        step(use_rn(4)); #1;
        check("fwd.youngest", int'(if_f.fwd_sel_rn), 1);
        step(nop()); step(nop());
        s = wr(4, 1'b0); s.wb = 1'b0;
        step(s);
        step(use_rn(4)); #1;
        check("fwd.no_wb", int'(if_f.fwd_sel_rn), 0);

        // Flush beats a load-use hazard; the flushed writer becomes a bubble
        step(nop()); step(nop());
        step(wr(5, 1'b1));
        s = use_rn(5); s.flush = 1'b1; s.wb = 1'b1; s.dest = 6;
        step(s); #1;
        check("fwd.flush.stall", int'(if_f.stall), 0);
        step(nop()); #1;
        check("fwd.flush.inflight", int'(if_f.inflight), 1);

        // Saturation: 20 stall-only stall cycles on a 4-bit counter
        repeat (10) begin
            step(wr(3, 1'b0));
            step(use_rn(3));
            step(use_rn(3));
        end
        step(nop()); #1;
        check("stl.cnt_saturated", int'(if_s.stall_cnt), CNT_MAX);

        // Reset in the middle of a stall
        step(wr(3, 1'b0));
        s = use_rn(3); s.rst = 1'b1;
        step(s); #1;
        check("stl.pre_reset_stall", int'(if_s.stall), 1);
        step(use_rn(3)); #1;
        check("stl.post_reset.stall",    int'(if_s.stall),      0);
        check("stl.post_reset.cnt",      int'(if_s.stall_cnt),  0);
        check("stl.post_reset.inflight", int'(if_s.inflight),   0);
        check("fwd.post_reset.sel",      int'(if_f.fwd_sel_rn), 0);

        // Random traffic over a small register range to provoke hazards
        repeat (3000) begin
            s.valid   = ($urandom_range(0, 9) < 8);
            s.rn      = int'($urandom_range(0, 3));
            s.rm      = int'($urandom_range(0, 3));
            s.rn_used = ($urandom_range(0, 3) != 0);
            s.rm_used = ($urandom_range(0, 1) != 0);
            s.wb      = ($urandom_range(0, 3) != 0);
            s.mr      = ($urandom_range(0, 2) == 0);
            s.dest    = int'($urandom_range(0, 3));
            s.flush   = ($urandom_range(0, 9) == 0);
            s.rst     = ($urandom_range(0, 149) == 0);
            step(s);
        end

        step(nop());
        @(negedge clk);
        #1;
        check("expect_queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
